// File: rtl/shared_window_arbiter_pkg.sv
// rtl/shared_window_arbiter_pkg.sv - shared types and width helper for the window arbiter
package shared_window_arbiter_pkg;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Ceiling log2 with a floor of 1 so single-entry ranges still get a bit.
    function automatic int clog2_w(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin winner search starting at ptr
module rr_priority_pick
    import shared_window_arbiter_pkg::*;
#(
    parameter int REQ_COUNT = 4,
    parameter int ID_WIDTH  = clog2_w(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0] valid,
    input  logic [ID_WIDTH-1:0]  ptr,
    input  logic [REQ_COUNT-1:0] mask,
    output logic [REQ_COUNT-1:0] winner,
    output logic [ID_WIDTH-1:0]  index,
    output logic                 found
);

    logic [REQ_COUNT-1:0] cand;

    assign cand = valid & mask;

    // First pass covers ptr..top, second pass wraps to the lowest candidate.
    always_comb begin
        winner = '0;
        index  = '0;
        found  = 1'b0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (!found && cand[i] && (ID_WIDTH'(i) >= ptr)) begin
                found     = 1'b1;
                index     = ID_WIDTH'(i);
                winner[i] = 1'b1;
            end
        end
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (!found && cand[i]) begin
                found     = 1'b1;
                index     = ID_WIDTH'(i);
                winner[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_window_arbiter.sv
// rtl/shared_window_arbiter.sv - round-robin arbiter with window check, translation and lock
module shared_window_arbiter
    import shared_window_arbiter_pkg::*;
#(
    parameter int REQ_COUNT   = 4,
    parameter int ADDR_WIDTH  = 10,
    parameter int ADDR_BASE   = 0,
    parameter int ADDR_COUNT  = 8,
    parameter int LOCAL_WIDTH = 3,
    parameter int DATA_WIDTH  = 36,
    parameter int ID_WIDTH    = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [REQ_COUNT-1:0]             req_valid,
    output logic [REQ_COUNT-1:0]             req_ready,
    input  logic [REQ_COUNT-1:0]             req_lock,
    input  logic [REQ_COUNT-1:0]             req_write,
    input  logic [REQ_COUNT*ADDR_WIDTH-1:0]  req_address,
    input  logic [REQ_COUNT*DATA_WIDTH-1:0]  req_wdata,
    output logic                             grant_valid,
    input  logic                             grant_ready,
    output logic [ID_WIDTH-1:0]              grant_id,
    output logic [LOCAL_WIDTH-1:0]           grant_local,
    output logic                             grant_write,
    output logic [DATA_WIDTH-1:0]            grant_wdata,
    output logic                             range_error,
    output logic [ID_WIDTH-1:0]              error_id
);

    localparam logic [ID_WIDTH-1:0]    LAST_ID  = ID_WIDTH'(REQ_COUNT - 1);
    localparam logic [LOCAL_WIDTH-1:0] BASE_LOW = LOCAL_WIDTH'(ADDR_BASE);
    localparam logic [ADDR_WIDTH:0]    WIN_LO   = (ADDR_WIDTH + 1)'(ADDR_BASE);
    localparam logic [ADDR_WIDTH:0]    WIN_HI   = (ADDR_WIDTH + 1)'(ADDR_BASE + ADDR_COUNT);

    lock_state_t             state;
    logic [ID_WIDTH-1:0]     ptr;
    logic [ID_WIDTH-1:0]     owner;

    logic                    stage_free;
    logic [REQ_COUNT-1:0]    mask;
    logic [REQ_COUNT-1:0]    win_onehot;
    logic [ID_WIDTH-1:0]     win_index;
    logic                    win_found;
    logic                    accept;

    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_write;
    logic                    sel_lock;
    logic [ADDR_WIDTH:0]     addr_ext;
    logic                    in_window;
    logic [LOCAL_WIDTH-1:0]  sel_local;
    logic [ID_WIDTH-1:0]     next_ptr;

    assign stage_free = !grant_valid || grant_ready;
    assign mask       = (state == LOCKED) ? (REQ_COUNT'(1) << owner) : '1;

    rr_priority_pick #(
        .REQ_COUNT (REQ_COUNT),
        .ID_WIDTH  (ID_WIDTH)
    ) u_pick (
        .valid  (req_valid),
        .ptr    (ptr),
        .mask   (mask),
        .winner (win_onehot),
        .index  (win_index),
        .found  (win_found)
    );

    assign req_ready = (stage_free && !reset) ? win_onehot : '0;
    assign accept    = stage_free && win_found;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        sel_lock  = 1'b0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (win_onehot[i]) begin
                sel_addr  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_write = req_write[i];
                sel_lock  = req_lock[i];
            end
        end
    end

    // Extra top bit keeps BASE+COUNT from wrapping at the top of the address space.
    assign addr_ext  = {1'b0, sel_addr};
    assign in_window = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    assign sel_local = sel_addr[LOCAL_WIDTH-1:0] - BASE_LOW;
    assign next_ptr  = (win_index == LAST_ID) ? '0 : win_index + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_valid <= 1'b0;
            grant_id    <= '0;
            grant_local <= '0;
            grant_write <= 1'b0;
            grant_wdata <= '0;
            range_error <= 1'b0;
            error_id    <= '0;
            ptr         <= '0;
            owner       <= '0;
            state       <= UNLOCKED;
        end else begin
            range_error <= 1'b0;
            if (stage_free) begin
                grant_valid <= accept && in_window;
                if (accept && in_window) begin
                    grant_id    <= win_index;
                    grant_local <= sel_local;
                    grant_write <= sel_write;
                    grant_wdata <= sel_wdata;
                end
                if (accept && !in_window) begin
                    range_error <= 1'b1;
                    error_id    <= win_index;
                end
                // Lock state follows req_lock of every consumed request, in or out of window.
                if (accept) begin
                    if (sel_lock) begin
                        state <= LOCKED;
                        owner <= win_index;
                        ptr   <= win_index;
                    end else begin
                        state <= UNLOCKED;
                        ptr   <= next_ptr;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_shared_window_arbiter.sv
// tb/tb_shared_window_arbiter.sv - randomized self-checking bench with a behavioural model
module tb_shared_window_arbiter;

    localparam int REQ   = 4;
    localparam int AW    = 10;
    localparam int BASE  = 5;
    localparam int COUNT = 6;
    localparam int LW    = 3;
    localparam int DW    = 36;
    localparam int IW    = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [REQ-1:0]    req_valid = '0;
    logic [REQ-1:0]    req_ready;
    logic [REQ-1:0]    req_lock = '0;
    logic [REQ-1:0]    req_write = '0;
    logic [REQ*AW-1:0] req_address;
    logic [REQ*DW-1:0] req_wdata;
    logic              grant_valid;
    logic              grant_ready = 1'b1;
    logic [IW-1:0]     grant_id;
    logic [LW-1:0]     grant_local;
    logic              grant_write;
    logic [DW-1:0]     grant_wdata;
    logic              range_error;
    logic [IW-1:0]     error_id;

    logic [AW-1:0]     addr  [REQ];
    logic [DW-1:0]     wdata [REQ];

    int checks   = 0;
    int failures = 0;

    int            m_ptr, m_owner;
    bit            m_locked;
    logic          m_gv, m_gwrite, m_rerr;
    logic [IW-1:0] m_gid, m_eid;
    logic [LW-1:0] m_glocal;
    logic [DW-1:0] m_gwdata;
    logic [REQ-1:0] obs_ready, exp_ready;

    always #5 clock = ~clock;

    for (genvar g = 0; g < REQ; g++) begin : g_pack
        assign req_address[g*AW +: AW] = addr[g];
        assign req_wdata[g*DW +: DW]   = wdata[g];
    end

    shared_window_arbiter #(
        .REQ_COUNT   (REQ),
        .ADDR_WIDTH  (AW),
        .ADDR_BASE   (BASE),
        .ADDR_COUNT  (COUNT),
        .LOCAL_WIDTH (LW),
        .DATA_WIDTH  (DW),
        .ID_WIDTH    (IW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_lock    (req_lock),
        .req_write   (req_write),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_id    (grant_id),
        .grant_local (grant_local),
        .grant_write (grant_write),
        .grant_wdata (grant_wdata),
        .range_error (range_error),
        .error_id    (error_id)
    );

    function automatic int model_pick();
        for (int k = 0; k < REQ; k++) begin
            int i;
            i = (m_ptr + k) % REQ;
            if (m_locked && i != m_owner) continue;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_ptr = 0; m_owner = 0; m_locked = 0;
        m_gv = 0; m_gwrite = 0; m_rerr = 0;
        m_gid = '0; m_eid = '0; m_glocal = '0; m_gwdata = '0;
    endtask

    // One clock: sample handshake mid-low-phase, then advance the model across the edge.
    task automatic tick();
        int  w, a;
        bit  free;
        #2;
        free = !m_gv || grant_ready;
        w = free ? model_pick() : -1;
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        obs_ready = req_ready;
        @(posedge clock);
        m_rerr = 0;
        if (free) begin
            m_gv = 0;
            if (w >= 0) begin
                a = int'(addr[w]);
                if (a >= BASE && a < BASE + COUNT) begin
                    m_gv = 1; m_gid = IW'(w); m_glocal = LW'(a - BASE);
                    m_gwrite = req_write[w]; m_gwdata = wdata[w];
                end else begin
                    m_rerr = 1; m_eid = IW'(w);
                end
                if (req_lock[w]) begin
                    m_locked = 1; m_owner = w; m_ptr = w;
                end else begin
                    m_locked = 0; m_ptr = (w + 1) % REQ;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_clear();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '1;
        for (int i = 0; i < REQ; i++) begin addr[i] = AW'(BASE); wdata[i] = '0; end
        reset = 1'b1;
        #1;
        model_clear();
        checks++;
        if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        checks++;
        if ({grant_valid, grant_id, grant_local, grant_write, grant_wdata, range_error, error_id} !== '0) begin
            failures++;
            $display("FAIL reset_outputs gv=%b id=%0d loc=%0d w=%b wd=%h re=%b eid=%0d exp all zero",
                     grant_valid, grant_id, grant_local, grant_write, grant_wdata, range_error, error_id);
        end
        @(negedge clock);
        reset = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        logic [LW-1:0] exp_loc [2];
        logic [AW-1:0] raw [2];
        raw[0] = 10'd5; raw[1] = 10'd10; exp_loc[0] = 3'd0; exp_loc[1] = 3'd5;
        for (int k = 0; k < 2; k++) begin
            req_valid = 4'b0100; req_write = '0; addr[2] = raw[k]; wdata[2] = DW'(k + 7);
            checks++;
            if (grant_valid !== m_gv) begin failures++; $display("FAIL single_pre_gv got=%b exp=%b", grant_valid, m_gv); end
            tick();
            checks++;
            if (obs_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", obs_ready); end
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== 2'd2 || grant_local !== exp_loc[k] || grant_wdata !== DW'(k + 7)) begin
                failures++;
                $display("FAIL single_grant raw=%0d gv=%b id=%0d loc=%0d wd=%0d exp gv=1 id=2 loc=%0d wd=%0d",
                         raw[k], grant_valid, grant_id, grant_local, grant_wdata, exp_loc[k], k + 7);
            end
        end
        req_valid = '0;
        tick();
        checks++;
        if (grant_valid !== 1'b0) begin failures++; $display("FAIL single_drain gv got=%b exp=0", grant_valid); end
    endtask

    task automatic test_round_robin();
        logic [LW-1:0] exp_loc;
        do_reset();
        req_valid = '1; req_lock = '0; grant_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < REQ; i++) begin
                addr[i] = AW'(BASE + $urandom_range(0, COUNT - 1));
                wdata[i] = DW'({$urandom, $urandom});
                req_write[i] = 1'($urandom);
            end
            exp_loc = LW'(int'(addr[k % REQ]) - BASE);
            tick();
            checks++;
            if (obs_ready !== (4'b0001 << (k % REQ))) begin
                failures++; $display("FAIL rr_ready step=%0d got=%b exp=%b", k, obs_ready, 4'b0001 << (k % REQ));
            end
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== IW'(k % REQ) || grant_local !== exp_loc ||
                grant_wdata !== wdata[k % REQ] || grant_write !== req_write[k % REQ]) begin
                failures++;
                $display("FAIL rr_grant step=%0d gv=%b id=%0d loc=%0d exp gv=1 id=%0d loc=%0d",
                         k, grant_valid, grant_id, grant_local, k % REQ, exp_loc);
            end
        end
    endtask

    task automatic test_stall();
        logic [IW-1:0] h_id;
        logic [LW-1:0] h_loc;
        logic [DW-1:0] h_wd;
        h_id = m_gid; h_loc = m_glocal; h_wd = m_gwdata;
        grant_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < REQ; i++) addr[i] = AW'(BASE + $urandom_range(0, COUNT - 1));
            tick();
            checks++;
            if (obs_ready !== '0) begin failures++; $display("FAIL stall_ready step=%0d got=%b exp=0", k, obs_ready); end
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== h_id || grant_local !== h_loc || grant_wdata !== h_wd) begin
                failures++;
                $display("FAIL stall_hold step=%0d gv=%b id=%0d loc=%0d exp gv=1 id=%0d loc=%0d",
                         k, grant_valid, grant_id, grant_local, h_id, h_loc);
            end
        end
        grant_ready = 1'b1;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== IW'((int'(h_id) + 1) % REQ)) begin
            failures++; $display("FAIL stall_resume gv=%b id=%0d exp gv=1 id=%0d", grant_valid, grant_id, (int'(h_id) + 1) % REQ);
        end
    endtask

    task automatic test_range_error();
        logic [AW-1:0] raw [4];
        bit            inw [4];
        raw[0] = 10'd4;   inw[0] = 0;
        raw[1] = 10'd11;  inw[1] = 0;
        raw[2] = 10'd10;  inw[2] = 1;
        raw[3] = 10'h3FF; inw[3] = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b0010; addr[1] = raw[k];
            tick();
            checks++;
            if (obs_ready !== 4'b0010) begin failures++; $display("FAIL range_ready raw=%0d got=%b exp=0010", raw[k], obs_ready); end
            checks++;
            if (grant_valid !== inw[k] || range_error !== !inw[k] || (!inw[k] && error_id !== 2'd1)) begin
                failures++;
                $display("FAIL range_flags raw=%0d gv=%b re=%b eid=%0d exp gv=%0d re=%0d eid=1",
                         raw[k], grant_valid, range_error, error_id, inw[k], !inw[k]);
            end
        end
        req_valid = 4'b0010; addr[1] = 10'd4;
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (range_error !== 1'b0) begin failures++; $display("FAIL range_pulse re=%b exp=0", range_error); end
    endtask

    task automatic test_lock();
        logic [IW-1:0] exp_id [6];
        exp_id[0] = 2'd2; exp_id[1] = 2'd3; exp_id[2] = 2'd3;
        exp_id[3] = 2'd3; exp_id[4] = 2'd3; exp_id[5] = 2'd0;
        do_reset();
        grant_ready = 1'b1;
        for (int i = 0; i < REQ; i++) addr[i] = AW'(BASE + i);
        for (int k = 0; k < 6; k++) begin
            req_valid = (k == 0) ? 4'b0100 : 4'b1111;
            req_lock  = (k >= 1 && k <= 3) ? 4'b1000 : 4'b0000;
            tick();
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== exp_id[k]) begin
                failures++; $display("FAIL lock_seq step=%0d gv=%b id=%0d exp gv=1 id=%0d", k, grant_valid, grant_id, exp_id[k]);
            end
        end
    endtask

    task automatic test_reset_locked();
        req_valid = '1; req_lock = 4'b0010;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin
            failures++; $display("FAIL rstlock_pre gv=%b id=%0d exp gv=1 id=1", grant_valid, grant_id);
        end
        req_lock = '0;
        reset = 1'b1;
        #1;
        model_clear();
        checks++;
        if (grant_valid !== 1'b0 || grant_id !== '0 || grant_local !== '0 || req_ready !== '0) begin
            failures++;
            $display("FAIL rstlock_async gv=%b id=%0d loc=%0d ready=%b exp all zero", grant_valid, grant_id, grant_local, req_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            failures++; $display("FAIL rstlock_after gv=%b id=%0d exp gv=1 id=0", grant_valid, grant_id);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < REQ; i++) begin
                req_valid[i] = ($urandom_range(0, 2) != 0);
                req_lock[i]  = ($urandom_range(0, 5) == 0);
                req_write[i] = 1'($urandom);
                addr[i]      = ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
                wdata[i]     = DW'({$urandom, $urandom});
            end
            grant_ready = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (obs_ready !== exp_ready) begin
                failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", n, obs_ready, exp_ready);
            end
            checks++;
            if (grant_valid !== m_gv || range_error !== m_rerr) begin
                failures++; $display("FAIL rand_flags cyc=%0d gv=%b re=%b exp gv=%b re=%b", n, grant_valid, range_error, m_gv, m_rerr);
            end
            if (m_gv) begin
                checks++;
                if (grant_id !== m_gid || grant_local !== m_glocal || grant_write !== m_gwrite || grant_wdata !== m_gwdata) begin
                    failures++;
                    $display("FAIL rand_grant cyc=%0d id=%0d loc=%0d w=%b wd=%h exp id=%0d loc=%0d w=%b wd=%h",
                             n, grant_id, grant_local, grant_write, grant_wdata, m_gid, m_glocal, m_gwrite, m_gwdata);
                end
            end
            if (m_rerr) begin
                checks++;
                if (error_id !== m_eid) begin failures++; $display("FAIL rand_errid cyc=%0d got=%0d exp=%0d", n, error_id, m_eid); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_range_error();
        test_lock();
        test_reset_locked();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
